// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and limits for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_LAT_MAX = 15;
endpackage

// File: rtl/dmem_lat_counter.sv
// dmem_lat_counter: access-latency down-counter; loads on accept, counts down while waiting.
module dmem_lat_counter
  import dmem_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);
  localparam int CW = $clog2(DMEM_LAT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? CW'(LATENCY - 1) : dec_i ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // WAIT spans LATENCY cycles, so the last wait cycle is the one that sees zero
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready handshake with fixed latency.
// Optional misaligned-access error enabled by DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  dmem_state_t state_q, state_d;
  logic wr_q, mis_q, mis_d, err_q, accept, done, commit, unused_addr;
  logic [ADDR_W-1:0] idx_q;
  logic [DMEM_DATA_W-1:0] wdata_q, rdata_q, rdata_d;
  logic [DMEM_DATA_W-1:0] mem_q [2**ADDR_W];
  assign accept = state_q == IDLE && req_valid_i;
  assign commit = state_q == WAIT && done;
  assign unused_addr = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_d = req_addr_i[1:0] != 2'b00;
`else
  assign mis_d = 1'b0;
`endif
  dmem_lat_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(accept),
    .dec_i (state_q == WAIT && !done),
    .done_o(done)
  );
  always_comb begin
    state_d = state_q == IDLE ? (req_valid_i ? WAIT : IDLE)
            : state_q == WAIT ? (done ? RESP : WAIT)
            : (resp_ready_i ? IDLE : RESP);
    rdata_d = (wr_q || mis_q) ? '0 : mem_q[idx_q];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write_i;
        idx_q   <= req_addr_i[ADDR_W+1:2];
        wdata_q <= req_wdata_i;
        mis_q   <= mis_d;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= mis_q;
      end
    end
  end
  // a store reset while still waiting never reaches storage
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wr_q && !mis_q) mem_q[idx_q] <= wdata_q;
  end
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
endmodule
